// File: rtl/blake2_bus_host_if.sv
// Signal bundle between the blake2 bus host, its byte source/hash sink and the core bus.
// The master view is the host itself; slave is the environment around it.
interface blake2_bus_host_if;
    logic       in_valid_i;
    logic       in_ready_o;
    logic [7:0] in_data_i;
    logic [1:0] in_cmd_i;
    logic       in_last_i;
    logic [7:0] data_o;
    logic [2:0] data_ctrl_o;
    logic [7:0] hash_i;
    logic [1:0] hash_ctrl_i;
    logic       out_valid_o;
    logic [7:0] out_data_o;
    logic       out_last_o;
    logic       busy_o;
    logic       timeout_o;

    modport master (
        input  in_valid_i, in_data_i, in_cmd_i, in_last_i, hash_i, hash_ctrl_i,
        output in_ready_o, data_o, data_ctrl_o, out_valid_o, out_data_o, out_last_o,
        output busy_o, timeout_o
    );

    modport slave (
        output in_valid_i, in_data_i, in_cmd_i, in_last_i, hash_i, hash_ctrl_i,
        input  in_ready_o, data_o, data_ctrl_o, out_valid_o, out_data_o, out_last_o,
        input  busy_o, timeout_o
    );
endinterface

// File: rtl/blake2_bus_host.sv
// Host-side blake2 bus driver: paces source bytes onto the data bus using the core's
// ready flag, then collects HASH_BYTES hash bytes with an inactivity timeout.
module blake2_bus_host #(
    parameter int unsigned HASH_BYTES = 32,
    parameter int unsigned GAP_CYC    = 4,
    parameter int unsigned TIMEOUT    = 4095
) (
    input logic               clk,
    input logic               rst_async,
    blake2_bus_host_if.master bus
);

    localparam int unsigned GW = $clog2(GAP_CYC + 1);
    localparam int unsigned BW = $clog2(HASH_BYTES + 1);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        GAP,
        WAIT_HASH,
        READ
    } state_t;

    state_t          state;
    logic [GW-1:0]   gap_cnt;
    logic [BW-1:0]   byte_cnt;
    logic [TW-1:0]   to_cnt;
    logic            last_q;
    logic            accept;
    logic            hash_vld;
    logic            to_expire;

    assign bus.in_ready_o = (state == IDLE) && bus.hash_ctrl_i[0];
    assign accept         = bus.in_valid_i && bus.in_ready_o;
    assign hash_vld       = bus.hash_ctrl_i[1];
    // This cycle's increment would bring the counter to TIMEOUT.
    assign to_expire      = (to_cnt == TW'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst_async) begin
        if (rst_async) begin
            state           <= IDLE;
            gap_cnt         <= '0;
            byte_cnt        <= '0;
            to_cnt          <= '0;
            last_q          <= 1'b0;
            bus.data_o      <= '0;
            bus.data_ctrl_o <= '0;
            bus.out_valid_o <= 1'b0;
            bus.out_data_o  <= '0;
            bus.out_last_o  <= 1'b0;
            bus.busy_o      <= 1'b0;
            bus.timeout_o   <= 1'b0;
        end else begin
            bus.out_valid_o <= 1'b0;
            bus.out_last_o  <= 1'b0;
            // Stays high for one cycle after returning to IDLE.
            bus.busy_o      <= (state != IDLE) || accept;

            case (state)
                IDLE: begin
                    if (accept) begin
                        bus.data_o      <= bus.in_data_i;
                        bus.data_ctrl_o <= {bus.in_cmd_i, 1'b1};
                        last_q          <= bus.in_last_i;
                        gap_cnt         <= GW'(GAP_CYC - 1);
                        state           <= GAP;
                    end
                end

                GAP: begin
                    bus.data_ctrl_o[0] <= 1'b0;
                    if (gap_cnt == '0) begin
                        state <= last_q ? WAIT_HASH : IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end

                WAIT_HASH: begin
                    if (hash_vld) begin
                        bus.out_valid_o <= 1'b1;
                        bus.out_data_o  <= bus.hash_i;
                        to_cnt          <= '0;
                        if (HASH_BYTES == 1) begin
                            bus.out_last_o <= 1'b1;
                            byte_cnt       <= '0;
                            state          <= IDLE;
                        end else begin
                            byte_cnt <= BW'(1);
                            state    <= READ;
                        end
                    end else if (to_expire) begin
                        bus.timeout_o <= 1'b1;
                        to_cnt        <= '0;
                        byte_cnt      <= '0;
                        state         <= IDLE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end

                READ: begin
                    if (hash_vld) begin
                        bus.out_valid_o <= 1'b1;
                        bus.out_data_o  <= bus.hash_i;
                        to_cnt          <= '0;
                        if (byte_cnt == BW'(HASH_BYTES - 1)) begin
                            bus.out_last_o <= 1'b1;
                            byte_cnt       <= '0;
                            state          <= IDLE;
                        end else begin
                            byte_cnt <= byte_cnt + 1'b1;
                        end
                    end else if (to_expire) begin
                        bus.timeout_o <= 1'b1;
                        to_cnt        <= '0;
                        byte_cnt      <= '0;
                        state         <= IDLE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
